fetch_unit: RTL and testbench

Instruction-fetch sequencer feeding the decode and branch logic. It holds the fetch PC and issues word requests to instruction memory over a req/ack handshake. It presents fetched instructions with a valid/stall handshake and consumes the taken/target decision produced by the branch unit. Redirects flush any in-flight fetch, so no wrong-path instruction ever reaches the output.

---
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer.
// Holds the fetch PC, issues word requests to instruction memory over a
// req/ack handshake, presents fetched words with a valid/stall handshake and
// applies branch redirects, flushing any fetch that is in flight.
module fetch_unit #(
  parameter int unsigned     BITS     = 32,
  parameter logic [BITS-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic [BITS-1:0] target,
  input  logic            stall,
  output logic            imem_req,
  output logic [BITS-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic            instr_valid,
  output logic [31:0]     instruction,
  output logic [BITS-1:0] pc,
  output logic            misalign
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t          r_state;
  logic [BITS-1:0] r_fetch_pc;
  logic [BITS-1:0] r_flush_addr;
  logic [BITS-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic            r_misalign;

  logic            w_slot_free;
  logic            w_req;
  logic            w_accept;
  logic [BITS-1:0] w_target_aligned;

  // The request depends on this cycle's stall so a stalled, occupied slot
  // never issues. Once issued it cannot drop before the ack: a request seen
  // with a full slot implies stall=0, so that slot empties on the same edge.
  assign w_slot_free      = !r_valid || !stall;
  assign w_req            = ((r_state == FETCH) && w_slot_free) || (r_state == FLUSH);
  assign w_accept         = (r_state == FETCH) && w_req && imem_ack;
  assign w_target_aligned = {target[BITS-1:2], 2'b00};

  assign imem_req    = w_req;
  // While flushing, the old request must stay on the bus until it completes.
  assign imem_addr   = (r_state == FLUSH) ? r_flush_addr : r_fetch_pc;
  assign instr_valid = r_valid;
  assign instruction = r_instr;
  assign pc          = r_pc;
  assign misalign    = r_misalign;

  // Sequencer: state, fetch PC and presented instruction slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_fetch_pc   <= RESET_PC;
      r_flush_addr <= RESET_PC;
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_valid      <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_misalign <= 1'b0;
      if (branch) begin
        r_fetch_pc <= w_target_aligned;
        r_valid    <= 1'b0;
        r_misalign <= |target[1:0];
        case (r_state)
          FETCH: begin
            if (w_req && !imem_ack) begin
              r_state      <= FLUSH;
              r_flush_addr <= r_fetch_pc;
            end else begin
              r_state <= FETCH;
            end
          end
          FLUSH:   r_state <= imem_ack ? FETCH : FLUSH;
          default: r_state <= FETCH;
        endcase
      end else begin
        case (r_state)
          IDLE: r_state <= FETCH;
          FETCH: begin
            if (w_accept) begin
              r_instr    <= imem_data;
              r_pc       <= r_fetch_pc;
              r_valid    <= 1'b1;
              r_fetch_pc <= r_fetch_pc + BITS'(4);
            end else if (r_valid && !stall) begin
              r_valid <= 1'b0;
            end
          end
          FLUSH: begin
            if (imem_ack) r_state <= FETCH;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;

  localparam int unsigned BITS = 32;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst;
  logic            branch;
  logic [BITS-1:0] target;
  logic            stall;
  logic            imem_req;
  logic [BITS-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic [BITS-1:0] pc;
  logic            misalign;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;
  exp_t sb[$];

  fetch_unit #(
    .BITS     (BITS),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .branch      (branch),
    .target      (target),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc),
    .misalign    (misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.pc  = p;
    e.ins = i;
    sb.push_back(e);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed instruction must be the next expected one.
  always @(negedge clk) begin
    if (!rst && instr_valid && !stall) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected: got pc %h ins %h expected none", pc, instruction);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", pc, e.pc);
        chk("sb_ins", instruction, e.ins);
      end
    end
  end

  initial begin
    rst = 1'b1; branch = 1'b0; target = '0; stall = 1'b0;
    imem_ack = 1'b0; imem_data = '0;
    next_cycle(); next_cycle();
    to_neg();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_ins", instruction, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'd0);
    next_cycle();

    // Release reset: one IDLE cycle with no request.
    rst = 1'b0;
    to_neg();
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    next_cycle();

    // Back-to-back fetches 0,4,8.
    imem_ack = 1'b1; imem_data = 32'h00A00093; push(32'h0, 32'h00A00093);
    to_neg();
    chk("b2b0_req", {31'b0, imem_req}, 32'd1);
    chk("b2b0_addr", imem_addr, 32'h0);
    chk("b2b0_valid", {31'b0, instr_valid}, 32'd0);
    next_cycle();
    imem_data = 32'h00B00113; push(32'h4, 32'h00B00113);
    to_neg();
    chk("b2b1_addr", imem_addr, 32'h4);
    chk("b2b1_valid", {31'b0, instr_valid}, 32'd1);
    next_cycle();
    imem_data = 32'h002081B3; push(32'h8, 32'h002081B3);
    to_neg();
    chk("b2b2_addr", imem_addr, 32'h8);
    chk("b2b2_valid", {31'b0, instr_valid}, 32'd1);
    next_cycle();
    imem_ack = 1'b0;
    to_neg();
    chk("b2b3_valid", {31'b0, instr_valid}, 32'd1);
    chk("b2b3_addr", imem_addr, 32'hC);
    next_cycle();

    // Fetch 0xC, then stall three cycles with it presented.
    imem_ack = 1'b1; imem_data = 32'h00000533; push(32'hC, 32'h00000533);
    to_neg();
    chk("drain_valid", {31'b0, instr_valid}, 32'd0);
    next_cycle();
    imem_ack = 1'b0; stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      to_neg();
      chk("stall_req", {31'b0, imem_req}, 32'd0);
      chk("stall_pc", pc, 32'hC);
      chk("stall_ins", instruction, 32'h00000533);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      next_cycle();
    end
    stall = 1'b0;
    to_neg();
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h10);
    next_cycle();

    // Branch to 0x40 while the request to 0x10 is pending.
    branch = 1'b1; target = 32'h40;
    to_neg();
    chk("br_req", {31'b0, imem_req}, 32'd1);
    chk("br_addr", imem_addr, 32'h10);
    next_cycle();
    branch = 1'b0;
    to_neg();
    chk("flush_addr", imem_addr, 32'h10);
    chk("flush_req", {31'b0, imem_req}, 32'd1);
    chk("flush_valid", {31'b0, instr_valid}, 32'd0);
    next_cycle();
    imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
    to_neg();
    chk("flush_ack_addr", imem_addr, 32'h10);
    next_cycle();
    imem_ack = 1'b0;
    to_neg();
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    next_cycle();
    imem_ack = 1'b1; imem_data = 32'h00100073; push(32'h40, 32'h00100073);
    to_neg();
    next_cycle();

    // Misaligned branch to 0x42 with an ack in the same cycle.
    branch = 1'b1; target = 32'h42; imem_data = 32'hBAD0BAD0;
    to_neg();
    chk("mis_pre", {31'b0, misalign}, 32'd0);
    chk("mis_pre_addr", imem_addr, 32'h44);
    next_cycle();
    branch = 1'b0; imem_ack = 1'b0;
    to_neg();
    chk("mis_pulse", {31'b0, misalign}, 32'd1);
    chk("mis_valid", {31'b0, instr_valid}, 32'd0);
    chk("mis_addr", imem_addr, 32'h40);
    next_cycle();

    // Branch to 0xFFFFFFFC while 0x40 is pending; flush, then wrap.
    branch = 1'b1; target = 32'hFFFFFFFC;
    to_neg();
    chk("mis_clear", {31'b0, misalign}, 32'd0);
    next_cycle();
    branch = 1'b0; imem_ack = 1'b1; imem_data = 32'h12345678;
    to_neg();
    chk("wrapfl_addr", imem_addr, 32'h40);
    next_cycle();
    imem_data = 32'h00200093; push(32'hFFFFFFFC, 32'h00200093);
    to_neg();
    chk("wrap_addr0", imem_addr, 32'hFFFFFFFC);
    next_cycle();
    imem_ack = 1'b0;
    to_neg();
    chk("wrap_valid", {31'b0, instr_valid}, 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);
    next_cycle();

    // Redirect to 0x10 with ack in the same cycle, then reset mid-request.
    branch = 1'b1; target = 32'h10; imem_ack = 1'b1; imem_data = 32'hCAFEF00D;
    to_neg();
    next_cycle();
    branch = 1'b0; imem_ack = 1'b0; rst = 1'b1;
    to_neg();
    chk("prerst_req", {31'b0, imem_req}, 32'd1);
    chk("prerst_addr", imem_addr, 32'h10);
    next_cycle();
    rst = 1'b0; imem_ack = 1'b1; imem_data = 32'hFEEDFACE;
    to_neg();
    chk("postrst_req", {31'b0, imem_req}, 32'd0);
    chk("postrst_valid", {31'b0, instr_valid}, 32'd0);
    chk("postrst_pc", pc, 32'h0);
    chk("postrst_ins", instruction, NOP);
    next_cycle();
    imem_data = 32'h00300093; push(32'h0, 32'h00300093);
    to_neg();
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_valid", {31'b0, instr_valid}, 32'd0);
    next_cycle();
    imem_ack = 1'b0;
    to_neg();
    chk("restart_v", {31'b0, instr_valid}, 32'd1);
    next_cycle();
    next_cycle();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
